// File: rtl/soc_rst_seq_pkg.sv
// Shared types and widths for the SoC reset sequencer.
package soc_rst_seq_pkg;

    localparam int unsigned RETRY_W = 4;
    localparam int unsigned LOSS_W  = 8;

    localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/soc_sync2.sv
// Two-flop synchronizer for a single asynchronous control bit.
module soc_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the asynchronous input; both flops clear on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/soc_rst_seq.sv
// PLL reset / lock-acquisition sequencer producing the system reset request.
module soc_rst_seq
    import soc_rst_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pll_locked,
    output logic              pll_rst,
    output logic              sys_reset_n,
    output logic              pll_fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  lock_loss_cnt
);

    localparam int unsigned CNT_MAX = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                           LOCK_TIMEOUT_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    // Terminal counts; each is below 2**CNT_W, so the counter never wraps.
    localparam logic [CNT_W-1:0]   PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             locked_s;

    soc_sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // Sequencer FSM; outputs are registered alongside each state transition.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_PLL_RST;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            sys_reset_n   <= 1'b0;
            pll_fail      <= 1'b0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
        end else begin
            case (state)
                ST_PLL_RST: begin
                    if (cnt == PLL_LAST) begin
                        state   <= ST_WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TMO_LAST) begin
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        if (retry_cnt == RETRY_LIMIT) begin
                            state    <= ST_FAIL;
                            pll_fail <= 1'b1;
                        end else begin
                            state     <= ST_PLL_RST;
                            retry_cnt <= retry_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_STABLE: begin
                    if (!locked_s) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state       <= ST_RUN;
                        cnt         <= '0;
                        sys_reset_n <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (!locked_s) begin
                        state       <= ST_PLL_RST;
                        cnt         <= '0;
                        pll_rst     <= 1'b1;
                        sys_reset_n <= 1'b0;
                        retry_cnt   <= '0;
                        if (lock_loss_cnt != LOSS_MAX) begin
                            lock_loss_cnt <= lock_loss_cnt + 1'b1;
                        end
                    end
                end

                ST_FAIL: begin
                    cnt         <= '0;
                    pll_rst     <= 1'b1;
                    sys_reset_n <= 1'b0;
                    pll_fail    <= 1'b1;
                end

                default: begin
                    state       <= ST_PLL_RST;
                    cnt         <= '0;
                    pll_rst     <= 1'b1;
                    sys_reset_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_rst_seq.sv
// Self-checking bench for soc_rst_seq: vector table, directed corner cases,
// and randomized lock/reset stimulus against a deadline-based timeline model.
module tb_soc_rst_seq;

    localparam int P = 4;
    localparam int S = 8;
    localparam int T = 32;
    localparam int R = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       pll_fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    soc_rst_seq #(
        .PLL_RST_CYCLES      (P),
        .LOCK_STABLE_CYCLES  (S),
        .LOCK_TIMEOUT_CYCLES (T),
        .MAX_RETRIES         (R)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sys_reset_n   (sys_reset_n),
        .pll_fail      (pll_fail),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    // Timeline model: a named phase plus the absolute edge number at which
    // the phase's timer expires; lock seen through a 2-deep delay line.
    string m_phase = "PLL_RST";
    int    m_cyc = 0;
    int    m_deadline = 0;
    int    m_retry = 0;
    int    m_loss = 0;
    bit    m_failf = 1'b0;
    bit    m_sync[$] = '{1'b0, 1'b0};

    function void model_step(input bit rn, input bit lk);
        bit ls;
        m_cyc++;
        if (!rn) begin
            m_phase    = "PLL_RST";
            m_deadline = m_cyc + P;
            m_sync     = '{1'b0, 1'b0};
            m_retry    = 0;
            m_loss     = 0;
            m_failf    = 1'b0;
            return;
        end
        ls = m_sync.pop_front();
        m_sync.push_back(lk);
        if (m_phase == "PLL_RST") begin
            if (m_cyc == m_deadline) begin
                m_phase    = "WAIT_LOCK";
                m_deadline = m_cyc + T;
            end
        end else if (m_phase == "WAIT_LOCK") begin
            if (ls) begin
                m_phase    = "STABLE";
                m_deadline = m_cyc + S;
            end else if (m_cyc == m_deadline) begin
                if (m_retry == R) begin
                    m_phase = "FAIL";
                    m_failf = 1'b1;
                end else begin
                    m_retry    = m_retry + 1;
                    m_phase    = "PLL_RST";
                    m_deadline = m_cyc + P;
                end
            end
        end else if (m_phase == "STABLE") begin
            if (!ls) begin
                m_phase    = "WAIT_LOCK";
                m_deadline = m_cyc + T;
            end else if (m_cyc == m_deadline) begin
                m_phase = "RUN";
            end
        end else if (m_phase == "RUN") begin
            if (!ls) begin
                m_phase    = "PLL_RST";
                m_deadline = m_cyc + P;
                m_retry    = 0;
                m_loss     = (m_loss < 255) ? m_loss + 1 : 255;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] dut_vec();
        return {pll_rst, sys_reset_n, pll_fail, retry_cnt, lock_loss_cnt};
    endfunction

    task automatic check_model();
        logic [14:0] exp;
        exp = {(m_phase == "PLL_RST" || m_phase == "FAIL"), (m_phase == "RUN"),
               m_failf, 4'(m_retry), 8'(m_loss)};
        check($sformatf("model[%s]", m_phase), 32'(dut_vec()), 32'(exp));
    endtask

    task automatic tick(input bit rn, input bit lk);
        reset_n    = rn;
        pll_locked = lk;
        @(posedge clk);
        model_step(rn, lk);
        #1;
        check_model();
    endtask

    typedef struct {
        bit rn;
        bit lk;
        int n;
        bit e_rst;
        bit e_sys;
        bit e_fail;
        int e_retry;
        int e_loss;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int k;
        int rst_seen;
        bit lk;
        bit rn;

        reset_n    = 1'b0;
        pll_locked = 1'b0;

        tbl[0]  = '{0, 0, 3,  1, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 3,  1, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 1,  0, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 10, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 10, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 1, 1,  0, 1, 0, 0, 0};
        tbl[6]  = '{1, 0, 1,  0, 1, 0, 0, 0};
        tbl[7]  = '{1, 1, 1,  0, 1, 0, 0, 0};
        tbl[8]  = '{1, 1, 1,  1, 0, 0, 0, 1};
        tbl[9]  = '{1, 1, 3,  1, 0, 0, 0, 1};
        tbl[10] = '{1, 1, 1,  0, 0, 0, 0, 1};
        tbl[11] = '{1, 1, 8,  0, 0, 0, 0, 1};
        tbl[12] = '{1, 1, 1,  0, 1, 0, 0, 1};
        tbl[13] = '{0, 0, 2,  1, 0, 0, 0, 0};
        tbl[14] = '{1, 0, 35, 0, 0, 0, 0, 0};
        tbl[15] = '{1, 0, 1,  1, 0, 0, 1, 0};
        tbl[16] = '{1, 0, 71, 0, 0, 0, 2, 0};
        tbl[17] = '{1, 0, 1,  1, 0, 1, 2, 0};
        tbl[18] = '{1, 1, 20, 1, 0, 1, 2, 0};
        tbl[19] = '{0, 1, 1,  1, 0, 0, 0, 0};

        for (int i = 0; i < 20; i++) begin
            repeat (tbl[i].n) tick(tbl[i].rn, tbl[i].lk);
            check($sformatf("vec%0d", i), 32'(dut_vec()),
                  32'({tbl[i].e_rst, tbl[i].e_sys, tbl[i].e_fail,
                       4'(tbl[i].e_retry), 8'(tbl[i].e_loss)}));
        end

        // Lock drop during STABLE: back to WAIT_LOCK without a PLL pulse,
        // then a full stable window before release.
        tick(0, 1);
        tick(0, 1);
        repeat (5) tick(1, 1);
        repeat (2) tick(1, 1);
        tick(1, 0);
        rst_seen = 0;
        k = 0;
        while (sys_reset_n !== 1'b1 && k < 40) begin
            tick(1, 1);
            k++;
            if (pll_rst === 1'b1) rst_seen++;
        end
        check("relock_latency", 32'(k - 1), 32'(10));
        check("no_pll_rst_in_stable", 32'(rst_seen), 32'(0));

        // Reset asserted mid-STABLE, then a normal restart.
        tick(0, 1);
        repeat (5) tick(1, 1);
        repeat (3) tick(1, 1);
        tick(0, 1);
        check("rst_mid_stable", 32'(dut_vec()), 32'({1'b1, 1'b0, 1'b0, 4'd0, 8'd0}));
        repeat (13) tick(1, 1);
        check("restart_run", 32'(sys_reset_n), 32'(1));

        // 300 one-cycle lock losses; the loss counter must stop at 255.
        for (int n = 0; n < 300; n++) begin
            tick(1, 0);
            tick(1, 1);
            tick(1, 1);
            k = 0;
            while (sys_reset_n !== 1'b1 && k < 40) begin
                tick(1, 1);
                k++;
            end
            if (sys_reset_n !== 1'b1) begin
                check("relock_bound", 32'(sys_reset_n), 32'(1));
                break;
            end
        end
        check("loss_saturated", 32'(lock_loss_cnt), 32'(255));

        // Randomized lock glitches and occasional resets.
        lk = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 29) == 0) lk = ~lk;
            rn = ($urandom_range(0, 399) != 0);
            tick(rn, lk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, failed=%0d", n_fail);
        $fatal(1);
    end

endmodule
